// File: rtl/key_event_fifo_if.sv
// Handshake bundle between the keypad event queue and its consumer.
interface key_event_fifo_if;
  logic [15:0] key;
  logic        pop;
  logic        clr_ovf;
  logic [15:0] pressed;
  logic [3:0]  code;
  logic        valid;
  logic        overflow;

  modport master (
    output key, pop, clr_ovf,
    input  pressed, code, valid, overflow
  );

  modport slave (
    input  key, pop, clr_ovf,
    output pressed, code, valid, overflow
  );
endinterface

// File: rtl/key_event_fifo.sv
// Debounces a 16-key keypad, turns each debounced press into a 4-bit code
// and queues the codes in a small FIFO drained through a valid/pop handshake.
module key_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  key_event_fifo_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

  logic [15:0]      r_s1;
  logic [15:0]      r_s2;
  logic [15:0]      r_pressed;
  logic [15:0]      r_pressed_d;
  logic [15:0]      r_pending;
  logic [CNT_W-1:0] r_cnt [16];
  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;

  logic [15:0] w_rise;
  logic [15:0] w_sel_mask;
  logic [3:0]  w_sel_idx;
  logic        w_has_sel;
  logic        w_empty;
  logic        w_full;
  logic        w_pop_acc;
  logic        w_push;
  logic        w_drop;

  assign w_rise     = r_pressed & ~r_pressed_d;
  assign w_has_sel  = |r_pending;
  // Two's-complement trick isolates the lowest pending bit.
  assign w_sel_mask = r_pending & (~r_pending + 16'd1);

  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = 4'(i);
    end
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_acc = bus.pop & ~w_empty;
  assign w_push    = w_has_sel & (~w_full | w_pop_acc);
  assign w_drop    = w_has_sel & ~w_push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_pressed   <= '0;
      r_pressed_d <= '0;
      for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
    end else begin
      r_s1        <= bus.key;
      r_s2        <= r_s1;
      r_pressed_d <= r_pressed;
      for (int i = 0; i < 16; i++) begin
        if (r_s2[i] == r_pressed[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_pressed[i] <= r_s2[i];
          r_cnt[i]     <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A rise in the same cycle as the clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_sel_mask) | w_rise;
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_sel_idx;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop) r_overflow <= 1'b1;
      else if (bus.clr_ovf) r_overflow <= 1'b0;
    end
  end

  assign bus.pressed  = r_pressed;
  assign bus.valid    = ~w_empty;
  assign bus.code     = w_empty ? 4'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_key_event_fifo.sv
// Self-checking bench: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_key_event_fifo;

  localparam int DB    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  key_event_fifo_if bus();

  key_event_fifo #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mD1 = '0;
  logic [15:0] mD2 = '0;
  logic [15:0] mPressed = '0;
  logic [15:0] mPressedPrev = '0;
  logic [15:0] mPending = '0;
  int          mRun [16];
  int          mQ [$];
  bit          mOvf = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [15:0] k, input logic p,
                               input logic c);
    bus.key     = k;
    bus.pop     = p;
    bus.clr_ovf = c;
  endtask

  // Reference behaviour: a level is accepted after DB consecutive disagreeing
  // synchronized samples; presses queue in ascending order, dropped when full.
  task automatic modelEdge();
    logic [15:0] rise;
    bit popAcc;
    bit drop;
    int sel;
    if (!rst_n) begin
      mD1 = '0; mD2 = '0; mPressed = '0; mPressedPrev = '0; mPending = '0;
      mOvf = 1'b0;
      for (int i = 0; i < 16; i++) mRun[i] = 0;
      mQ.delete();
    end else begin
      rise   = mPressed & ~mPressedPrev;
      popAcc = bus.pop && (mQ.size() > 0);
      drop   = 1'b0;
      sel    = -1;
      for (int i = 0; i < 16; i++) if (mPending[i] && sel < 0) sel = i;
      if (popAcc) void'(mQ.pop_front());
      if (sel >= 0) begin
        if (mQ.size() < DEPTH) mQ.push_back(sel);
        else drop = 1'b1;
        mPending[sel] = 1'b0;
      end
      mPending = mPending | rise;
      if (drop) mOvf = 1'b1;
      else if (bus.clr_ovf) mOvf = 1'b0;
      mPressedPrev = mPressed;
      for (int i = 0; i < 16; i++) begin
        if (mD2[i] == mPressed[i]) mRun[i] = 0;
        else begin
          mRun[i]++;
          if (mRun[i] == DB) begin
            mPressed[i] = mD2[i];
            mRun[i] = 0;
          end
        end
      end
      mD2 = mD1;
      mD1 = bus.key;
    end
  endtask

  task automatic compareAll();
    checkOutput("pressed", bus.pressed, mPressed);
    checkOutput("valid", bus.valid, (mQ.size() > 0));
    checkOutput("code", bus.code, (mQ.size() > 0) ? mQ[0] : 0);
    checkOutput("overflow", bus.overflow, mOvf);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic stepN(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  task automatic waitPressed(input int idx, output int n);
    n = 99;
    for (int k = 1; k <= 40; k++) begin
      stepCycle();
      if (bus.pressed[idx]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic popExpect(input int exp);
    checkOutput("head_code", bus.code, exp);
    checkOutput("head_valid", bus.valid, 1);
    bus.pop = 1'b1;
    stepCycle();
    bus.pop = 1'b0;
  endtask

  initial begin
    int n;
    int bounce [7];
    bounce = '{1, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 16; i++) mRun[i] = 0;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    stepN(2);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_pressed", bus.pressed, 0);
    checkOutput("rst_valid", bus.valid, 0);
    checkOutput("rst_code", bus.code, 0);
    checkOutput("rst_overflow", bus.overflow, 0);

    // Single clean press: pressed at the 6th edge counting the first sample.
    applyStimulus(16'h0020, 1'b0, 1'b0);
    waitPressed(5, n);
    checkOutput("press_latency", n, DB + 2);
    stepCycle();
    checkOutput("valid_a1", bus.valid, 0);
    stepCycle();
    checkOutput("valid_a2", bus.valid, 1);
    popExpect(5);
    checkOutput("pop_valid", bus.valid, 0);
    checkOutput("pop_code", bus.code, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepN(10);

    // Bounce: short runs must not be accepted.
    for (int i = 0; i < 7; i++) begin
      bus.key = bounce[i] ? 16'h0004 : 16'h0000;
      stepCycle();
      checkOutput("bounce_pressed", bus.pressed[2], 0);
    end
    stepN(10);
    popExpect(2);
    checkOutput("bounce_once", bus.valid, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepN(10);

    // Simultaneous keys leave in ascending order.
    applyStimulus(16'h0208, 1'b0, 1'b0);
    waitPressed(3, n);
    checkOutput("simul_pressed", bus.pressed, 16'h0208);
    stepN(2);
    popExpect(3);
    popExpect(9);
    checkOutput("simul_empty", bus.valid, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepN(10);

    // Overflow: fifth press dropped with no pops.
    for (int k = 0; k < 5; k++) begin
      bus.key = 16'(1) << k;
      stepN(12);
    end
    bus.key = 16'h0000;
    stepN(10);
    checkOutput("ovf_set", bus.overflow, 1);
    checkOutput("ovf_head", bus.code, 0);
    bus.clr_ovf = 1'b1;
    stepCycle();
    bus.clr_ovf = 1'b0;
    checkOutput("ovf_clr", bus.overflow, 0);
    bus.pop = 1'b1;
    stepCycle();
    bus.pop = 1'b0;
    bus.key = 16'h0020;
    waitPressed(5, n);
    bus.pop = 1'b1;
    stepCycle();
    bus.pop = 1'b0;
    bus.key = 16'h0040;
    waitPressed(6, n);
    stepCycle();
    bus.pop = 1'b1;
    stepCycle();
    bus.pop = 1'b0;
    checkOutput("full_pushpop_noovf", bus.overflow, 0);
    popExpect(3);
    popExpect(5);
    popExpect(6);
    checkOutput("ovf_drained", bus.valid, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepN(10);

    // Reset mid-operation discards queued and pending codes.
    applyStimulus(16'h0003, 1'b0, 1'b0);
    stepN(12);
    bus.key = 16'h0083;
    waitPressed(7, n);
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    checkOutput("mid_rst_valid", bus.valid, 0);
    checkOutput("mid_rst_pressed", bus.pressed, 0);
    checkOutput("mid_rst_ovf", bus.overflow, 0);
    waitPressed(7, n);
    checkOutput("post_rst_latency", n, DB + 2);
    stepN(4);
    popExpect(0);
    popExpect(1);
    popExpect(7);
    checkOutput("post_rst_empty", bus.valid, 0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    stepN(10);

    // Pop while empty is ignored.
    bus.pop = 1'b1;
    stepN(3);
    bus.pop = 1'b0;
    checkOutput("underflow_valid", bus.valid, 0);
    bus.key = 16'h0040;
    waitPressed(6, n);
    stepN(3);
    popExpect(6);
    checkOutput("underflow_single", bus.valid, 0);
    stepN(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
